// File: rtl/big_alu_pkg.sv
// Shared definitions for the main datapath ALU: operand width, operation
// codes and the small helpers used by the flag logic.
package big_alu_pkg;

  localparam int ALU_WIDTH = 32;

  // Operation codes carried on ctrl; all eight encodings are defined.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLT  = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_OR   = 3'b111
  } alu_op_t;

  // Everything that gets registered at the output stage.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 zero;
    logic                 carryout;
    logic                 overflow;
  } alu_out_t;

  // Zero detect for the value being registered into result.
  function automatic logic is_zero(input logic [ALU_WIDTH-1:0] value);
    return (value == {ALU_WIDTH{1'b0}});
  endfunction

  // Ops that route ~in2 with a carry-in of 1 through the shared adder.
  function automatic logic uses_subtract(input alu_op_t op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/big_alu_adder32.sv
// 32-bit ripple-style adder shared by ADD, SUB and SLT. Produces the carry
// out of bit 31 and signed overflow of the sum relative to its operands.
import big_alu_pkg::*;

module adder32 (
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [ALU_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  logic [ALU_WIDTH:0] wide_sum_s;

  // Carry-extended addition and signed overflow of a + b + cin.
  always_comb begin
    wide_sum_s = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, cin};
    sum        = wide_sum_s[ALU_WIDTH-1:0];
    cout       = wide_sum_s[ALU_WIDTH];
    // Same operand signs but a different result sign means the signed
    // result did not fit.
    if ((a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
        (wide_sum_s[ALU_WIDTH-1] != a[ALU_WIDTH-1])) begin
      ovf = 1'b1;
    end else begin
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/big_alu.sv
// Main datapath ALU: eight operations on two 32-bit operands with result,
// zero, carry-out and signed overflow registered for one-cycle latency.
import big_alu_pkg::*;

module big_alu (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ALU_WIDTH-1:0] in1,
  input  logic [ALU_WIDTH-1:0] in2,
  input  logic [2:0]           ctrl,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 zero,
  output logic                 carryout,
  output logic                 overflow
);

  alu_op_t              op_s;
  logic [ALU_WIDTH-1:0] add_b_s;
  logic                 add_cin_s;
  logic [ALU_WIDTH-1:0] add_sum_s;
  logic                 add_cout_s;
  logic                 add_ovf_s;
  alu_out_t             next_s;
  alu_out_t             out_r;

  assign op_s = alu_op_t'(ctrl);

  // Select the second adder operand: subtraction paths use ~in2 + 1.
  always_comb begin
    if (uses_subtract(op_s)) begin
      add_b_s   = ~in2;
      add_cin_s = 1'b1;
    end else begin
      add_b_s   = in2;
      add_cin_s = 1'b0;
    end
  end

  adder32 u_adder (
    .a    (in1),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s),
    .ovf  (add_ovf_s)
  );

  // Operation mux and flag generation feeding the output register.
  always_comb begin
    next_s.result   = {ALU_WIDTH{1'b0}};
    next_s.carryout = 1'b0;
    next_s.overflow = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB: begin
        next_s.result   = add_sum_s;
        next_s.carryout = add_cout_s;
        next_s.overflow = add_ovf_s;
      end
      OP_SLT: begin
        // Sign of the difference corrected by overflow gives the true
        // signed less-than even when in1 - in2 wraps.
        next_s.result = {{(ALU_WIDTH-1){1'b0}}, add_sum_s[ALU_WIDTH-1] ^ add_ovf_s};
      end
      OP_XOR:  next_s.result = in1 ^ in2;
      OP_AND:  next_s.result = in1 & in2;
      OP_NAND: next_s.result = ~(in1 & in2);
      OP_NOR:  next_s.result = ~(in1 | in2);
      OP_OR:   next_s.result = in1 | in2;
      default: next_s.result = {ALU_WIDTH{1'b0}};
    endcase
    next_s.zero = is_zero(next_s.result);
  end

  // Output register stage; reset state is a zero result with zero flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r.result   <= {ALU_WIDTH{1'b0}};
      out_r.zero     <= 1'b1;
      out_r.carryout <= 1'b0;
      out_r.overflow <= 1'b0;
    end else begin
      out_r <= next_s;
    end
  end

  assign result   = out_r.result;
  assign zero     = out_r.zero;
  assign carryout = out_r.carryout;
  assign overflow = out_r.overflow;

endmodule

// File: tb/tb_big_alu.sv
// Self-checking bench for big_alu: directed cases with hand-derived
// expectations plus randomized operations against an arithmetic model.
module tb_big_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [2:0]  ctrl;
  logic [31:0] result;
  logic        zero;
  logic        carryout;
  logic        overflow;

  int n_checks;
  int n_fail;

  big_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .ctrl     (ctrl),
    .result   (result),
    .zero     (zero),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, zero, carryout, overflow} from plain arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    longint sa, sb, s;
    longint smax, smin;
    logic [31:0] r;
    logic co, ov;
    sa = $signed(a);
    sb = $signed(b);
    smax = longint'(32'sh7FFFFFFF);
    smin = longint'(32'sh80000000);
    co = 1'b0;
    ov = 1'b0;
    r  = 32'd0;
    case (c)
      3'd0: begin
        s  = sa + sb;
        r  = a + b;
        co = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
        ov = (s > smax) || (s < smin);
      end
      3'd1: begin
        s  = sa - sb;
        r  = a - b;
        co = (a >= b);
        ov = (s > smax) || (s < smin);
      end
      3'd2: r = a ^ b;
      3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, (r == 32'd0), co, ov};
  endfunction

  // Present one operation and let exactly one rising edge register it.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    in1  = a;
    in2  = b;
    ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    drive(32'h1234_5678, 32'h0000_0001, 3'd0);
    @(negedge clk);
    #2;
    in1  = 32'hDEAD_BEEF;
    in2  = 32'h0BAD_F00D;
    ctrl = 3'd7;
    rst_n = 1'b0;
    #1;
    got = {result, zero, carryout, overflow};
    n_checks++;
    if (got !== {32'h0000_0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got result=%h z=%b c=%b v=%b, expected result=00000000 z=1 c=0 v=0",
               result, zero, carryout, overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({result, zero, carryout, overflow} !== {32'h0000_0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got result=%h z=%b c=%b v=%b, expected 00000000 1 0 0",
               result, zero, carryout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] a_t [7];
    logic [31:0] b_t [7];
    logic [2:0]  c_t [7];
    logic [34:0] e_t [7];
    a_t[0] = 32'h0000_0001; b_t[0] = 32'h0000_0001; c_t[0] = 3'd0; e_t[0] = {32'h0000_0002, 1'b0, 1'b0, 1'b0};
    a_t[1] = 32'h7FFF_FFFF; b_t[1] = 32'h0000_0001; c_t[1] = 3'd0; e_t[1] = {32'h8000_0000, 1'b0, 1'b0, 1'b1};
    a_t[2] = 32'hFFFF_FFFF; b_t[2] = 32'h0000_0001; c_t[2] = 3'd0; e_t[2] = {32'h0000_0000, 1'b1, 1'b1, 1'b0};
    a_t[3] = 32'h0000_0005; b_t[3] = 32'h0000_0005; c_t[3] = 3'd1; e_t[3] = {32'h0000_0000, 1'b1, 1'b1, 1'b0};
    a_t[4] = 32'h8000_0000; b_t[4] = 32'h0000_0001; c_t[4] = 3'd1; e_t[4] = {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    a_t[5] = 32'h8000_0000; b_t[5] = 32'h0000_0001; c_t[5] = 3'd3; e_t[5] = {32'h0000_0001, 1'b0, 1'b0, 1'b0};
    a_t[6] = 32'h0000_0001; b_t[6] = 32'h8000_0000; c_t[6] = 3'd3; e_t[6] = {32'h0000_0000, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(a_t[i], b_t[i], c_t[i]);
      n_checks++;
      if ({result, zero, carryout, overflow} !== e_t[i]) begin
        n_fail++;
        $display("FAIL arith_%0d: ctrl=%0d a=%h b=%h got %h z=%b c=%b v=%b, expected %h z=%b c=%b v=%b",
                 i, c_t[i], a_t[i], b_t[i], result, zero, carryout, overflow,
                 e_t[i][34:3], e_t[i][2], e_t[i][1], e_t[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c_t [5];
    logic [31:0] r_t [5];
    c_t[0] = 3'd2; r_t[0] = 32'h0FF0_0FF0;
    c_t[1] = 3'd4; r_t[1] = 32'hF000_F000;
    c_t[2] = 3'd5; r_t[2] = 32'h0FFF_0FFF;
    c_t[3] = 3'd6; r_t[3] = 32'h000F_000F;
    c_t[4] = 3'd7; r_t[4] = 32'hFFF0_FFF0;
    // One op per cycle; after each edge the outputs show the op just taken.
    for (int i = 0; i < 5; i++) begin
      drive(32'hF0F0_F0F0, 32'hFF00_FF00, c_t[i]);
      n_checks++;
      if ({result, zero, carryout, overflow} !== {r_t[i], 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL logic_op_%0d: got %h z=%b c=%b v=%b, expected %h z=0 c=0 v=0",
                 c_t[i], result, zero, carryout, overflow, r_t[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
    in1  = 32'h0000_0003;
    in2  = 32'h0000_0004;
    ctrl = 3'd0;
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({result, zero, carryout, overflow} !== {32'h0000_0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midop_discard: got %h z=%b c=%b v=%b, expected 00000000 1 0 0",
               result, zero, carryout, overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({result, zero, carryout, overflow} !== {32'h0000_0007, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midop_first: got %h z=%b c=%b v=%b, expected 00000007 0 0 0",
               result, zero, carryout, overflow);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  c;
    logic [34:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = $urandom;
      c = 3'($urandom_range(7, 0));
      // Bias some operands toward sign and equality corner cases.
      if ((i % 8) == 0) b = a;
      if ((i % 8) == 1) a = {1'b1, 31'd0};
      if ((i % 8) == 2) b = {1'b0, {31{1'b1}}};
      exp_v = model(a, b, c);
      drive(a, b, c);
      n_checks++;
      if ({result, zero, carryout, overflow} !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: ctrl=%0d a=%h b=%h got %h z=%b c=%b v=%b, expected %h z=%b c=%b v=%b",
                 i, c, a, b, result, zero, carryout, overflow,
                 exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in1      = 32'd0;
    in2      = 32'd0;
    ctrl     = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/big_alu.md
# big_alu

32-bit registered arithmetic/logic unit performing one of eight operations on two 32-bit operands, selected by a 3-bit control code. It is the main datapath ALU of the processor, separate from the small PC-increment adder. Results and status flags (zero, carry-out, signed overflow) are registered on the clock edge, giving a fixed one-cycle latency.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: asynchronous, active-low reset.
- `in1` input 32: operand A.
- `in2` input 32: operand B.
- `ctrl` input 3: operation select.
- `result` output 32: registered operation result.
- `zero` output 1: registered flag, 1 when `result` equals 0.
- `carryout` output 1: registered carry-out of the adder.
- `overflow` output 1: registered signed two's-complement overflow.

## Operation
- `ctrl` encoding:
  - 000 ADD: in1 + in2.
  - 001 SUB: in1 − in2, computed as in1 + ~in2 + 1.
  - 010 XOR.
  - 011 SLT: signed less-than, result = {31'b0, in1 < in2 signed}.
  - 100 AND.
  - 101 NAND.
  - 110 NOR.
  - 111 OR.
- ADD and SUB results wrap modulo 2^32.
- `carryout`:
  - ADD: carry from bit 31.
  - SUB: carry from bit 31 of in1 + ~in2 + 1. This is 1 when there is no unsigned borrow, i.e. in1 ≥ in2 unsigned.
  - All other ops: 0.
- `overflow`:
  - ADD/SUB: 1 when both adder operand sign bits are equal and differ from the sum sign bit. For SUB, the second adder operand is ~in2.
  - All other ops: 0.
- SLT must give the correct signed answer even when the internal subtraction overflows. Use sign(diff) XOR overflow(diff).
- `zero` is derived from the same value that is registered into `result`, for every op.
- The logic ops ignore the adder.

## Timing
- All outputs are registered. Inputs sampled at rising edge N appear on the outputs after edge N. Latency is 1 cycle; throughput is one operation per cycle.
- No handshake. A new operation is accepted every cycle; outputs hold until the next edge.
- Reset (`rst_n` = 0): asynchronously forces `result` = 0, `carryout` = 0, `overflow` = 0, and `zero` = 1, which is consistent with result = 0.
- Reset mid-operation discards any in-flight result. The first edge after deassertion registers the current inputs.
- X or undefined `ctrl` values are not possible (3-bit, all codes defined).

## Structure
- Shared package `big_alu_pkg`:
  - `alu_op_t` enum with the eight codes above.
  - `ALU_WIDTH` = 32.
- One natural sub-module: `adder32`, a 32-bit adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, ovf.
  - Shared by ADD, SUB and SLT; SUB/SLT feed ~in2 with cin = 1.
- Remaining logic: combinational op mux and flag logic, feeding a single output register stage with async reset.

## Test plan
- Reset: assert `rst_n` = 0 with arbitrary inputs → result = 0x00000000, zero = 1, carryout = 0, overflow = 0, with no clock edge required.
- ADD basic: in1 = 0x00000001, in2 = 0x00000001, ctrl = 000 → after one edge, result = 0x00000002, zero = 0, carryout = 0, overflow = 0.
- ADD overflow/carry:
  - 0x7FFFFFFF + 0x00000001 → result = 0x80000000, overflow = 1, carryout = 0.
  - 0xFFFFFFFF + 0x00000001 → result = 0, zero = 1, carryout = 1, overflow = 0.
- SUB: 0x00000005 − 0x00000005 → result = 0, zero = 1, carryout = 1. Then 0x80000000 − 0x00000001 → result = 0x7FFFFFFF, overflow = 1.
- SLT with overflow: in1 = 0x80000000, in2 = 0x00000001, ctrl = 011 → result = 0x00000001. Swap operands → result = 0, zero = 1, carryout = 0, overflow = 0.
- Logic ops on in1 = 0xF0F0F0F0, in2 = 0xFF00FF00:
  - XOR → 0x0FF00FF0.
  - AND → 0xF000F000.
  - NAND → 0x0FFF0FFF.
  - NOR → 0x000F000F.
  - OR → 0xFFF0FFF0.
  - Each with carryout = overflow = 0.
  - Back-to-back, one op per cycle, each result one cycle after its inputs.
